// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: opcode encodings and field widths shared by the immediate extender
package imm_ext_pkg;
   localparam int EXT_OP_W = 3;
   localparam int INST_LO_W = 26;
   localparam logic [EXT_OP_W-1:0] EXT_2RI5U  = 3'd0;
   localparam logic [EXT_OP_W-1:0] EXT_2RI12  = 3'd1;
   localparam logic [EXT_OP_W-1:0] EXT_2RI12U = 3'd2;
   localparam logic [EXT_OP_W-1:0] EXT_1RI20  = 3'd3;
   localparam logic [EXT_OP_W-1:0] EXT_2RI16  = 3'd4;
   localparam logic [EXT_OP_W-1:0] EXT_I26    = 3'd5;
   localparam logic [EXT_OP_W-1:0] EXT_2RI14  = 3'd6;
   localparam logic [EXT_OP_W-1:0] EXT_RAW    = 3'd7;
endpackage

// File: rtl/imm_ext_lane.sv
// imm_ext_lane: extends one lane's immediate to XLEN and forms pc + imm
// IMM_EXT_PIPE_TGT_EN adds the target adder; without it tgt is tied to 0
module imm_ext_lane import imm_ext_pkg::*; #(
   parameter int XLEN = 32
) (
   input  logic [INST_LO_W-1:0] din,
   input  logic [EXT_OP_W-1:0]  op,
   input  logic [XLEN-1:0]      pc,
   output logic [XLEN-1:0]      imm,
   output logic [XLEN-1:0]      tgt
);
   logic [31:0] v;
   // zero-extended forms leave bit 31 clear, so a single sign extension covers every op
   always_comb begin
      case (op)
         EXT_2RI5U:  v = {27'd0, din[14:10]};
         EXT_2RI12:  v = {{20{din[21]}}, din[21:10]};
         EXT_2RI12U: v = {20'd0, din[21:10]};
         EXT_1RI20:  v = {din[24:5], 12'h000};
         EXT_2RI16:  v = {{14{din[25]}}, din[25:10], 2'b00};
         EXT_I26:    v = {{4{din[9]}}, din[9:0], din[25:10], 2'b00};
         EXT_2RI14:  v = {{16{din[23]}}, din[23:10], 2'b00};
         default:    v = {6'd0, din};
      endcase
   end
   assign imm = XLEN'($signed(v));
`ifdef IMM_EXT_PIPE_TGT_EN
   assign tgt = pc + imm;
`else
   logic unused_pc;
   assign unused_pc = ^pc;
   assign tgt = '0;
`endif
endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate-extend stage with 2-entry skid buffer and flush
// IMM_EXT_PIPE_TGT_EN enables the per-lane pc + imm target; otherwise out_tgt stays 0
module imm_ext_pipe import imm_ext_pkg::*; #(
   parameter int XLEN  = 32,
   parameter int LANES = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [LANES-1:0]              in_lane_vld,
   input  logic [LANES*INST_LO_W-1:0]    in_inst,
   input  logic [LANES*EXT_OP_W-1:0]     in_op,
   input  logic [LANES*XLEN-1:0]         in_pc,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LANES-1:0]              out_lane_vld,
   output logic [LANES*XLEN-1:0]         out_imm,
   output logic [LANES*XLEN-1:0]         out_tgt
);
   logic [LANES*XLEN-1:0] ext_imm, ext_tgt, skid_imm, skid_tgt;
   logic [LANES-1:0] skid_lane_vld;
   logic skid_valid, acc, adv;
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      imm_ext_lane #(.XLEN(XLEN)) u_lane (
         .din(in_inst[l*INST_LO_W +: INST_LO_W]),
         .op(in_op[l*EXT_OP_W +: EXT_OP_W]),
         .pc(in_pc[l*XLEN +: XLEN]),
         .imm(ext_imm[l*XLEN +: XLEN]),
         .tgt(ext_tgt[l*XLEN +: XLEN])
      );
   end
   assign in_ready = !skid_valid;
   assign acc = in_valid && !skid_valid;
   assign adv = !out_valid || out_ready;
   // main refills from skid first so beat order is preserved
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         out_valid     <= 1'b0;
         skid_valid    <= 1'b0;
         out_lane_vld  <= '0;
         out_imm       <= '0;
         out_tgt       <= '0;
         skid_lane_vld <= '0;
         skid_imm      <= '0;
         skid_tgt      <= '0;
      end else if (flush) begin
         out_valid     <= 1'b0;
         skid_valid    <= 1'b0;
         out_lane_vld  <= '0;
         skid_lane_vld <= '0;
      end else begin
         if (adv) out_valid <= skid_valid || acc;
         skid_valid <= !adv && (skid_valid || acc);
         if (adv && skid_valid) begin
            out_lane_vld <= skid_lane_vld;
            out_imm      <= skid_imm;
            out_tgt      <= skid_tgt;
         end else if (adv && acc) begin
            out_lane_vld <= in_lane_vld;
            out_imm      <= ext_imm;
            out_tgt      <= ext_tgt;
         end
         if (!adv && acc) begin
            skid_lane_vld <= in_lane_vld;
            skid_imm      <= ext_imm;
            skid_tgt      <= ext_tgt;
         end
      end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed checks on a 32-bit 2-lane and a 64-bit 1-lane instance
module tb_imm_ext_pipe;
`ifdef IMM_EXT_PIPE_TGT_EN
   localparam bit TGT_EN = 1'b1;
`else
   localparam bit TGT_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst, flush;
   always #5 clk = ~clk;
   int checks = 0;
   int failures = 0;
   logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [1:0] a_in_lane_vld, a_out_lane_vld;
   logic [51:0] a_in_inst;
   logic [5:0] a_in_op;
   logic [63:0] a_in_pc, a_out_imm, a_out_tgt;
   logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [0:0] b_in_lane_vld, b_out_lane_vld;
   logic [25:0] b_in_inst;
   logic [2:0] b_in_op;
   logic [63:0] b_in_pc, b_out_imm, b_out_tgt;
   imm_ext_pipe #(.XLEN(32), .LANES(2)) u_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_lane_vld(a_in_lane_vld),
      .in_inst(a_in_inst), .in_op(a_in_op), .in_pc(a_in_pc),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_lane_vld(a_out_lane_vld),
      .out_imm(a_out_imm), .out_tgt(a_out_tgt)
   );
   imm_ext_pipe #(.XLEN(64), .LANES(1)) u_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_lane_vld(b_in_lane_vld),
      .in_inst(b_in_inst), .in_op(b_in_op), .in_pc(b_in_pc),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_lane_vld(b_out_lane_vld),
      .out_imm(b_out_imm), .out_tgt(b_out_tgt)
   );
   task automatic beat_a(input logic [1:0] lv, input logic [25:0] i0, i1,
                         input logic [2:0] o0, o1, input logic [31:0] p0, p1);
      a_in_valid = 1'b1;
      a_in_lane_vld = lv;
      a_in_inst = {i1, i0};
      a_in_op = {o1, o0};
      a_in_pc = {p1, p0};
   endtask
   task automatic test_reset;
      rst = 1'b1;
      flush = 1'b0;
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      a_in_lane_vld = '0; a_in_inst = '0; a_in_op = '0; a_in_pc = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b1;
      b_in_lane_vld = '0; b_in_inst = '0; b_in_op = '0; b_in_pc = '0;
      repeat (2) @(negedge clk);
      checks++; if ({a_out_valid, a_in_ready} !== 2'b01) begin failures++; $display("FAIL reset_a_hs got=%b exp=01", {a_out_valid, a_in_ready}); end
      checks++; if ({a_out_imm, a_out_tgt} !== 128'd0) begin failures++; $display("FAIL reset_a_data got=%h exp=0", {a_out_imm, a_out_tgt}); end
      checks++; if (a_out_lane_vld !== 2'b00) begin failures++; $display("FAIL reset_a_lv got=%b exp=00", a_out_lane_vld); end
      checks++; if ({b_out_valid, b_in_ready, b_out_imm, b_out_tgt} !== {2'b01, 128'd0}) begin failures++; $display("FAIL reset_b got=%b/%b/%h/%h exp=0/1/0/0", b_out_valid, b_in_ready, b_out_imm, b_out_tgt); end
      rst = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_ext32;
      beat_a(2'b11, 26'h03FFC00, 26'h03FFC00, 3'd1, 3'd2, 32'h0000_1000, 32'h0000_2000);
      @(negedge clk);
      a_in_valid = 1'b0;
      checks++; if ({a_out_valid, a_out_lane_vld} !== 3'b111) begin failures++; $display("FAIL ext32_valid got=%b exp=111", {a_out_valid, a_out_lane_vld}); end
      checks++; if (a_out_imm !== 64'h0000_0FFF_FFFF_FFFF) begin failures++; $display("FAIL ext32_imm got=%h exp=00000fffffffffff", a_out_imm); end
      checks++; if (a_out_tgt !== (TGT_EN ? 64'h0000_2FFF_0000_0FFF : 64'd0)) begin failures++; $display("FAIL ext32_tgt got=%h exp=%h", a_out_tgt, TGT_EN ? 64'h0000_2FFF_0000_0FFF : 64'd0); end
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL ext32_drain got=%b exp=0", a_out_valid); end
   endtask
   task automatic test_ext64;
      logic [2:0] ops[7] = '{3'd3, 3'd0, 3'd1, 3'd4, 3'd6, 3'd7, 3'd5};
      logic [25:0] ins[7] = '{26'h1000000, 26'h0007C00, 26'h01FFC00, 26'h2000000,
                              26'h0800000, 26'h3FFFFFF, 26'h3FFFFFF};
      logic [63:0] exps[7] = '{64'hFFFF_FFFF_8000_0000, 64'h1F, 64'h7FF, 64'hFFFF_FFFF_FFFE_0000,
                               64'hFFFF_FFFF_FFFF_8000, 64'h3FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC};
      logic [63:0] pc = 64'h0000_0001_1C00_0000;
      for (int i = 0; i < 7; i++) begin
         b_in_valid = 1'b1;
         b_in_lane_vld = 1'b1;
         b_in_op = ops[i];
         b_in_inst = ins[i];
         b_in_pc = pc;
         @(negedge clk);
         checks++; if ({b_out_valid, b_out_imm} !== {1'b1, exps[i]}) begin failures++; $display("FAIL ext64_imm[%0d] got=%b/%h exp=1/%h", i, b_out_valid, b_out_imm, exps[i]); end
         checks++; if (b_out_tgt !== (TGT_EN ? pc + exps[i] : 64'd0)) begin failures++; $display("FAIL ext64_tgt[%0d] got=%h exp=%h", i, b_out_tgt, TGT_EN ? pc + exps[i] : 64'd0); end
      end
      b_in_valid = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_tgt;
      beat_a(2'b11, 26'h3FFFFFF, 26'h0000800, 3'd5, 3'd4, 32'h1C00_0010, 32'hFFFF_FFFC);
      @(negedge clk);
      a_in_valid = 1'b0;
      checks++; if (a_out_imm !== 64'h0000_0008_FFFF_FFFC) begin failures++; $display("FAIL tgt_imm got=%h exp=00000008fffffffc", a_out_imm); end
      checks++; if (a_out_tgt !== (TGT_EN ? 64'h0000_0004_1C00_000C : 64'd0)) begin failures++; $display("FAIL tgt_sum got=%h exp=%h", a_out_tgt, TGT_EN ? 64'h0000_0004_1C00_000C : 64'd0); end
      @(negedge clk);
   endtask
   task automatic test_back_to_back;
      a_out_ready = 1'b0;
      beat_a(2'b11, 26'h11, 26'h11, 3'd7, 3'd7, 32'd0, 32'd0);
      @(negedge clk);
      checks++; if ({a_in_ready, a_out_valid, a_out_imm[31:0]} !== {2'b11, 32'h11}) begin failures++; $display("FAIL bp_a_main got=%b/%b/%h exp=1/1/11", a_in_ready, a_out_valid, a_out_imm[31:0]); end
      beat_a(2'b11, 26'h22, 26'h22, 3'd7, 3'd7, 32'd0, 32'd0);
      @(negedge clk);
      checks++; if ({a_in_ready, a_out_imm[31:0]} !== {1'b0, 32'h11}) begin failures++; $display("FAIL bp_b_skid got=%b/%h exp=0/11", a_in_ready, a_out_imm[31:0]); end
      beat_a(2'b11, 26'h33, 26'h33, 3'd7, 3'd7, 32'd0, 32'd0);
      @(negedge clk);
      checks++; if ({a_in_ready, a_out_imm[31:0]} !== {1'b0, 32'h11}) begin failures++; $display("FAIL bp_c_held got=%b/%h exp=0/11", a_in_ready, a_out_imm[31:0]); end
      a_out_ready = 1'b1;
      @(negedge clk);
      checks++; if ({a_in_ready, a_out_valid, a_out_imm[31:0]} !== {2'b11, 32'h22}) begin failures++; $display("FAIL bp_b_out got=%b/%b/%h exp=1/1/22", a_in_ready, a_out_valid, a_out_imm[31:0]); end
      @(negedge clk);
      a_in_valid = 1'b0;
      checks++; if ({a_in_ready, a_out_valid, a_out_imm[31:0]} !== {2'b11, 32'h33}) begin failures++; $display("FAIL bp_c_out got=%b/%b/%h exp=1/1/33", a_in_ready, a_out_valid, a_out_imm[31:0]); end
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", a_out_valid); end
   endtask
   task automatic test_flush;
      a_out_ready = 1'b0;
      beat_a(2'b11, 26'h44, 26'h44, 3'd7, 3'd7, 32'd0, 32'd0);
      @(negedge clk);
      beat_a(2'b11, 26'h55, 26'h55, 3'd7, 3'd7, 32'd0, 32'd0);
      @(negedge clk);
      checks++; if ({a_in_ready, a_out_valid} !== 2'b01) begin failures++; $display("FAIL flush_full got=%b exp=01", {a_in_ready, a_out_valid}); end
      flush = 1'b1;
      beat_a(2'b11, 26'h66, 26'h66, 3'd7, 3'd7, 32'd0, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      a_in_valid = 1'b0;
      checks++; if ({a_out_valid, a_in_ready, a_out_lane_vld} !== 4'b0100) begin failures++; $display("FAIL flush_clear got=%b exp=0100", {a_out_valid, a_in_ready, a_out_lane_vld}); end
      a_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flush_ghost[%0d] got=%b imm=%h exp=0", i, a_out_valid, a_out_imm); end
      end
   endtask
   task automatic test_squash_reset;
      a_out_ready = 1'b0;
      beat_a(2'b01, 26'h77, 26'h77, 3'd7, 3'd7, 32'h100, 32'h200);
      @(negedge clk);
      checks++; if ({a_out_valid, a_out_lane_vld} !== 3'b101) begin failures++; $display("FAIL squash_lv got=%b exp=101", {a_out_valid, a_out_lane_vld}); end
      checks++; if (a_out_imm !== 64'h0000_0077_0000_0077) begin failures++; $display("FAIL squash_imm got=%h exp=0000007700000077", a_out_imm); end
      beat_a(2'b11, 26'h88, 26'h88, 3'd7, 3'd7, 32'd0, 32'd0);
      @(negedge clk);
      a_in_valid = 1'b0;
      checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL squash_stall got=%b exp=0", a_in_ready); end
      #1 rst = 1'b1;
      #1;
      checks++; if ({a_out_valid, a_in_ready, a_out_lane_vld} !== 4'b0100) begin failures++; $display("FAIL async_rst_hs got=%b exp=0100", {a_out_valid, a_in_ready, a_out_lane_vld}); end
      checks++; if ({a_out_imm, a_out_tgt} !== 128'd0) begin failures++; $display("FAIL async_rst_data got=%h exp=0", {a_out_imm, a_out_tgt}); end
      #1 rst = 1'b0;
      a_out_ready = 1'b1;
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_after got=%b exp=0", a_out_valid); end
   endtask
   initial begin
      test_reset();
      test_ext32();
      test_ext64();
      test_tgt();
      test_back_to_back();
      test_flush();
      test_squash_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined successor to the decode-stage immediate extender.
- Extends immediates for LANES instructions per beat to XLEN bits (32 for LA32, 64 for LA64).
- Optionally computes the PC-relative target (pc + imm) for each lane.
- Sits between the decode and issue stages: one register stage with a valid/ready handshake, a 2-entry skid buffer, and a synchronous flush.

Parameters:
- XLEN, 32, datapath width of imm/pc/target (legal values 32, 64)
- LANES, 1, instructions per beat (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  pipeline flush (branch mispredict/exception), synchronous
- in_valid  in  1  upstream beat valid
- in_ready  out  1  this block can accept a beat
- in_lane_vld  in  LANES  per-lane valid within beat
- in_inst  in  LANES*26  inst[25:0] per lane, lane i at [26i+:26]
- in_op  in  LANES*3  extension opcode per lane
- in_pc  in  LANES*XLEN  pc per lane
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts
- out_lane_vld  out  LANES  registered per-lane valid
- out_imm  out  LANES*XLEN  extended immediate per lane
- out_tgt  out  LANES*XLEN  pc + imm per lane

Interface: one clock, clk; reset rst is asynchronous and active-high.

Behaviour:
- Opcode encoding, with d = din (inst[25:0]), S(x) = sign-extend x to XLEN, Z(x) = zero-extend x to XLEN:
  - 0 2RI5U: Z(d[14:10])
  - 1 2RI12: S(d[21:10])
  - 2 2RI12U: Z(d[21:10])
  - 3 1RI20: S({d[24:5],12'h000}). Sign-extension above bit 31 is new for XLEN=64.
  - 4 2RI16: S({d[25:10],2'b00})
  - 5 I26: S({d[9:0],d[25:10],2'b00})
  - 6 2RI14: S({d[23:10],2'b00})
  - 7 RAW: Z(d[25:0])
- Target: out_tgt = in_pc + imm, modulo 2^XLEN (wrap-around, no overflow flag). Computed for every op; consumers select.
- Latency: exactly 1 cycle from accepted beat (in_valid & in_ready) to out_valid when the output register is empty or draining.
- Storage: main output register plus skid register. in_ready = !skid_valid (registered, no combinational path from out_ready).
- Accept while output blocked: a beat accepted while out_valid & !out_ready goes to skid. When main drains, skid moves to main next cycle. Order is always preserved.
- Full: both entries full -> in_ready = 0. A beat presented while in_ready = 0 is ignored and must be held by upstream.
- Simultaneous accept and drain on a single-entry-full state: the new beat enters main, skid stays empty.
- Flush: next edge clears main and skid valids and out_lane_vld, regardless of in_valid or out_ready. A beat offered in the flush cycle is dropped. in_ready = 1 the cycle after flush.
- Lane squash: lanes with in_lane_vld = 0 propagate with out_lane_vld = 0. Their imm/tgt are don't-care but deterministic (computed normally).
- Reset: out_valid = 0, out_lane_vld = 0, out_imm = 0, out_tgt = 0, skid_valid = 0. Asserted mid-transfer, it discards both entries immediately (asynchronous).
- Data registers load only on accept (no toggling when idle).

Optional Feature:
- Macro IMM_EXT_PIPE_TGT_EN.
- Defined: per-lane XLEN adder present; out_tgt as above.
- Undefined: no adder, in_pc ignored, out_tgt tied to 0 (including after reset); all other behaviour identical.

Decomposition:
- Shared package imm_ext_pkg holds:
  - the 3-bit opcode constants (EXT_2RI5U=0 … EXT_RAW=7) and EXT_OP_W=3
  - INST_LO_W=26
- Sub-module imm_ext_lane: combinational extender for one lane (din, op, pc -> imm, tgt), instantiated LANES times via generate.
- Top level holds handshake, skid and flush logic only.

Test Plan:
- XLEN=32, op=1, d[21:10]=12'hFFF -> out_imm=32'hFFFF_FFFF one cycle after accept; op=2 with the same d -> 32'h0000_0FFF.
- XLEN=64, op=3, d[24:5]=20'h80000 -> out_imm=64'hFFFF_FFFF_8000_0000; op=0, d[14:10]=5'h1F -> 64'h1F.
- TGT_EN, XLEN=32, op=5, d[9:0]=10'h3FF, d[25:10]=16'hFFFF, pc=32'h1C00_0010 -> imm=32'hFFFF_FFFC, tgt=32'h1C00_000C; pc=32'hFFFF_FFFC with imm=8 -> tgt=32'h0000_0004 (wrap).
- Backpressure: hold out_ready=0 and send beats A,B,C back-to-back -> A in main, B in skid, in_ready=0 so C is held. Then out_ready=1 -> A, B, C emerge in order, no loss or duplication.
- Flush with main+skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed beats and the offered beat never appear.
- LANES=2, in_lane_vld=2'b01, then rst pulsed mid-stall -> out_lane_vld=01 for that beat; after rst, out_valid=0, out_imm=0, out_tgt=0 immediately, without waiting for a clk edge.
